// File: rtl/rq_req_arbiter.sv
// rq_req_arbiter
//   Packet-atomic round-robin arbiter that merges NUM_REQ AXI-Stream RQ
//   requesters onto one master port. A grant is held from the first beat
//   until that requester's tlast beat is accepted. Accepted beats pass
//   through a 2-entry register FIFO, so m_tready never reaches s_tready
//   combinationally.
//
// Ports
//   user_clk, user_reset_n    clock, asynchronous active-low reset
//   s_tdata/s_tuser/s_tkeep   packed per-requester payload (slice i = requester i)
//   s_tlast/s_tvalid          per-requester end of packet / valid
//   s_tready                  per-requester ready (registered)
//   m_tdata/m_tuser/m_tkeep/m_tlast/m_tvalid/m_tready   master stream
//   grant_id                  current or last granted requester
//   grant_active              high while a packet transfer is in progress
//   pkt_cnt                   packets forwarded on the master side (wraps)

module rq_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 137,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32
) (
  input  logic                             user_clk,
  input  logic                             user_reset_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_tdata,
  input  logic [NUM_REQ*USER_WIDTH-1:0]    s_tuser,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]    s_tkeep,
  input  logic [NUM_REQ-1:0]               s_tlast,
  input  logic [NUM_REQ-1:0]               s_tvalid,
  output logic [NUM_REQ-1:0]               s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [USER_WIDTH-1:0]            m_tuser,
  output logic [KEEP_WIDTH-1:0]            m_tkeep,
  output logic                             m_tlast,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [2:0]                       grant_id,
  output logic                             grant_active,
  output logic [31:0]                      pkt_cnt
);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t                  state, state_nxt;
  logic [2:0]              rr_ptr, rr_ptr_nxt;
  logic [2:0]              grant_nxt;
  logic [NUM_REQ-1:0]      s_tready_nxt;

  logic                    sel_found;
  logic [2:0]              sel_idx;

  logic [DATA_WIDTH-1:0]   in_data;
  logic [USER_WIDTH-1:0]   in_user;
  logic [KEEP_WIDTH-1:0]   in_keep;
  logic                    in_last;

  logic                    push, pop, acc_last;
  logic [1:0]              buf_cnt, buf_cnt_nxt;

  // Second FIFO entry; the head entry is the m_* output registers.
  logic [DATA_WIDTH-1:0]   b1_data;
  logic [USER_WIDTH-1:0]   b1_user;
  logic [KEEP_WIDTH-1:0]   b1_keep;
  logic                    b1_last;

  // Round-robin pick: first pass covers rr_ptr..NUM_REQ-1, second pass
  // wraps to 0..rr_ptr-1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!sel_found && s_tvalid[j] && (j >= 32'(rr_ptr))) begin
        sel_found = 1'b1;
        sel_idx   = j[2:0];
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!sel_found && s_tvalid[j] && (j < 32'(rr_ptr))) begin
        sel_found = 1'b1;
        sel_idx   = j[2:0];
      end
    end
  end

  // Payload mux from the granted requester.
  always_comb begin
    in_data = '0;
    in_user = '0;
    in_keep = '0;
    in_last = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (j[2:0] == grant_id) begin
        in_data = s_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        in_user = s_tuser[j*USER_WIDTH +: USER_WIDTH];
        in_keep = s_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
        in_last = s_tlast[j];
      end
    end
  end

  // s_tready is only ever set for the granted requester while in XFER.
  assign push     = |(s_tvalid & s_tready);
  assign pop      = m_tvalid & m_tready;
  assign acc_last = push & in_last;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (sel_found) begin
          state_nxt = ST_XFER;
          grant_nxt = sel_idx;
        end
      end
      ST_XFER: begin
        if (acc_last) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (grant_id == 3'(NUM_REQ - 1)) ? '0 : grant_id + 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   buf_cnt_nxt = buf_cnt + 2'd1;
      2'b01:   buf_cnt_nxt = buf_cnt - 2'd1;
      default: buf_cnt_nxt = buf_cnt;
    endcase
  end

  // s_tready is registered from next-cycle state, grant and occupancy, which
  // makes it equal to (XFER && granted && buf_cnt != 2) in every cycle while
  // keeping both s_tvalid and m_tready off any path into it.
  always_comb begin
    s_tready_nxt = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      s_tready_nxt[j] = (state_nxt == ST_XFER) && (buf_cnt_nxt != 2'd2) &&
                        (j[2:0] == grant_nxt);
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      s_tready     <= '0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      grant_id     <= grant_nxt;
      grant_active <= (state_nxt == ST_XFER);
      s_tready     <= s_tready_nxt;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      buf_cnt  <= '0;
      m_tvalid <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      buf_cnt  <= buf_cnt_nxt;
      m_tvalid <= (buf_cnt_nxt != 2'd0);
      if (pop && m_tlast) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end

  // FIFO payload storage, no reset needed. A push always lands in the head
  // when the head is empty or being popped with nothing behind it; otherwise
  // it goes to the second entry. A push at occupancy 2 cannot happen.
  always_ff @(posedge user_clk) begin
    case ({push, pop})
      2'b10: begin
        if (buf_cnt == 2'd0) begin
          m_tdata <= in_data;
          m_tuser <= in_user;
          m_tkeep <= in_keep;
          m_tlast <= in_last;
        end else begin
          b1_data <= in_data;
          b1_user <= in_user;
          b1_keep <= in_keep;
          b1_last <= in_last;
        end
      end
      2'b01: begin
        m_tdata <= b1_data;
        m_tuser <= b1_user;
        m_tkeep <= b1_keep;
        m_tlast <= b1_last;
      end
      2'b11: begin
        if (buf_cnt == 2'd1) begin
          m_tdata <= in_data;
          m_tuser <= in_user;
          m_tkeep <= in_keep;
          m_tlast <= in_last;
        end else begin
          m_tdata <= b1_data;
          m_tuser <= b1_user;
          m_tkeep <= b1_keep;
          m_tlast <= b1_last;
          b1_data <= in_data;
          b1_user <= in_user;
          b1_keep <= in_keep;
          b1_last <= in_last;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rq_req_arbiter.sv
module tb_rq_req_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 512;
  localparam int UW   = 137;
  localparam int KW   = DW / 32;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic [DW-1:0] data;
  } beat_t;

  logic                 user_clk     = 1'b0;
  logic                 user_reset_n = 1'b0;
  logic [NREQ*DW-1:0]   s_tdata      = '0;
  logic [NREQ*UW-1:0]   s_tuser      = '0;
  logic [NREQ*KW-1:0]   s_tkeep      = '0;
  logic [NREQ-1:0]      s_tlast      = '0;
  logic [NREQ-1:0]      s_tvalid     = '0;
  logic [NREQ-1:0]      s_tready;
  logic [DW-1:0]        m_tdata;
  logic [UW-1:0]        m_tuser;
  logic [KW-1:0]        m_tkeep;
  logic                 m_tlast;
  logic                 m_tvalid;
  logic                 m_tready     = 1'b1;
  logic [2:0]           grant_id;
  logic                 grant_active;
  logic [31:0]          pkt_cnt;

  rq_req_arbiter #(
    .NUM_REQ   (NREQ),
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW),
    .KEEP_WIDTH(KW)
  ) dut (
    .user_clk    (user_clk),
    .user_reset_n(user_reset_n),
    .s_tdata     (s_tdata),
    .s_tuser     (s_tuser),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tuser     (m_tuser),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .grant_id    (grant_id),
    .grant_active(grant_active),
    .pkt_cnt     (pkt_cnt)
  );

  always #5 user_clk = ~user_clk;

  // Driver queues (beats still to be offered), planning queues (packets not
  // yet placed in the expected output order) and the expected output stream.
  beat_t       req_q   [NREQ][$];
  beat_t       plan_q  [NREQ][$];
  int unsigned plan_len[NREQ][$];
  beat_t       exp_q[$];
  int unsigned stall_cnt[NREQ];
  int unsigned hs_cnt[NREQ];
  int unsigned tlast_cyc[$];
  int unsigned rr_model   = 0;
  int unsigned model_pkts = 0;
  int unsigned cyc        = 0;
  int unsigned n_checks   = 0;
  int unsigned n_fail     = 0;
  int          rdy_mode   = 0;   // 0: always ready, 1: stalled, 2: random
  bit          gap_en     = 1'b0;
  logic        prev_stall = 1'b0;
  beat_t       prev_m;

  task automatic chk(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic beat_t make_beat(int unsigned src, int unsigned idx, bit last);
    beat_t        b;
    logic [159:0] u;
    for (int j = 0; j < DW / 32; j++) b.data[j*32 +: 32] = $urandom();
    b.data[7:0]  = 8'(src);
    b.data[15:8] = 8'(idx);
    for (int j = 0; j < 5; j++) u[j*32 +: 32] = $urandom();
    b.user = u[UW-1:0];
    b.keep = KW'($urandom());
    b.last = last;
    return b;
  endfunction

  function automatic void add_pkt(int unsigned src, int unsigned len);
    beat_t b;
    for (int unsigned k = 0; k < len; k++) begin
      b = make_beat(src, k, (k == len - 1));
      req_q[src].push_back(b);
      plan_q[src].push_back(b);
    end
    plan_len[src].push_back(len);
  endfunction

  // Packet-level round robin: the next packet comes from the first requester
  // with pending work at or after the pointer; the pointer then moves past it.
  function automatic void plan();
    bit          found;
    int unsigned i;
    int unsigned n;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
        i = (rr_model + k) % NREQ;
        if (!found && plan_len[i].size() != 0) begin
          n = plan_len[i].pop_front();
          repeat (n) exp_q.push_back(plan_q[i].pop_front());
          rr_model = (i + 1) % NREQ;
          found    = 1'b1;
        end
      end
    end
  endfunction

  task automatic drive();
    beat_t b;
    for (int i = 0; i < NREQ; i++) begin
      if (req_q[i].size() != 0 && stall_cnt[i] == 0) begin
        b = req_q[i][0];
        s_tvalid[i]           = 1'b1;
        s_tdata[i*DW +: DW]   = b.data;
        s_tuser[i*UW +: UW]   = b.user;
        s_tkeep[i*KW +: KW]   = b.keep;
        s_tlast[i]            = b.last;
      end else begin
        s_tvalid[i] = 1'b0;
      end
      if (stall_cnt[i] != 0) stall_cnt[i]--;
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'b0;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Runs mid-cycle: records the handshakes that the next rising edge will
  // perform and checks the master beat against the expected stream.
  task automatic observe();
    beat_t b;
    beat_t cur;
    beat_t e;
    cur = {m_tlast, m_tkeep, m_tuser, m_tdata};
    chk("s_rdy_onehot", 1024'($onehot0(s_tready)), 1024'(1));
    for (int i = 0; i < NREQ; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        chk("s_grant", 1024'({grant_active, grant_id}), 1024'({1'b1, 3'(i)}));
        b = req_q[i].pop_front();
        hs_cnt[i]++;
        if (gap_en && !b.last) stall_cnt[i] = $urandom_range(0, 2);
      end
    end
    if (prev_stall) chk("m_hold", 1024'({m_tvalid, cur}), 1024'({1'b1, prev_m}));
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("m_unexpected", 1024'(1), 1024'(0));
      end else begin
        e = exp_q.pop_front();
        chk("m_beat", 1024'(cur), 1024'(e));
        if (e.last) model_pkts++;
      end
      if (m_tlast) tlast_cyc.push_back(cyc);
    end
    prev_stall = m_tvalid && !m_tready;
    prev_m     = cur;
  endtask

  task automatic cycle();
    @(negedge user_clk);
    cyc++;
    drive();
    #1;
    observe();
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (n < budget && exp_q.size() != 0) begin
      cycle();
      n++;
    end
    chk("drain_left", 1024'(exp_q.size()), 1024'(0));
    cycle();
    cycle();
    chk("idle_mvalid", 1024'(m_tvalid), 1024'(0));
    chk("pkt_cnt", 1024'(pkt_cnt), 1024'(model_pkts));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned n;
    int unsigned exp_cnt;

    // Reset state, then 20 idle cycles with no requests.
    user_reset_n = 1'b0;
    repeat (3) cycle();
    chk("rst_mvalid", 1024'(m_tvalid), 1024'(0));
    chk("rst_sready", 1024'(s_tready), 1024'(0));
    chk("rst_gid", 1024'(grant_id), 1024'(0));
    chk("rst_gact", 1024'(grant_active), 1024'(0));
    chk("rst_pktcnt", 1024'(pkt_cnt), 1024'(0));
    user_reset_n = 1'b1;
    repeat (20) begin
      cycle();
      chk("idle_mvalid", 1024'(m_tvalid), 1024'(0));
      chk("idle_gact", 1024'(grant_active), 1024'(0));
    end

    // Round-robin order 0,1,2,3,0 with 3-beat packets, 4 cycles each.
    tlast_cyc.delete();
    for (int unsigned r = 0; r < NREQ; r++) add_pkt(r, 3);
    add_pkt(0, 3);
    plan();
    drain(200);
    chk("rr_npkts", 1024'(tlast_cyc.size()), 1024'(5));
    for (int k = 1; k < tlast_cyc.size(); k++)
      chk("rr_period", 1024'(tlast_cyc[k] - tlast_cyc[k-1]), 1024'(4));

    // Packet atomicity: requester 2 pauses after beat 1 while 0 waits.
    base = hs_cnt[2];
    add_pkt(2, 4);
    plan();
    n = 0;
    while (n < 20 && hs_cnt[2] == base) begin
      cycle();
      n++;
    end
    chk("lock_start", 1024'(hs_cnt[2] - base), 1024'(1));
    stall_cnt[2] = 5;
    add_pkt(0, 3);
    plan();
    repeat (5) begin
      cycle();
      chk("lock_gid", 1024'(grant_id), 1024'(2));
      chk("lock_gact", 1024'(grant_active), 1024'(1));
      chk("lock_r0_wait", 1024'(s_tready[0]), 1024'(0));
    end
    drain(200);

    // Random mix: all requesters, lengths 1..5, mid-packet valid gaps,
    // random downstream ready.
    gap_en   = 1'b1;
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) add_pkt($urandom_range(0, NREQ - 1), $urandom_range(1, 5));
    plan();
    drain(5000);
    gap_en   = 1'b0;
    rdy_mode = 0;

    // Backpressure: 8-beat packet with downstream stalled for 10 cycles.
    base = hs_cnt[1];
    add_pkt(1, 8);
    plan();
    rdy_mode = 1;
    repeat (10) cycle();
    chk("bp_buffered", 1024'(hs_cnt[1] - base), 1024'(2));
    chk("bp_sready", 1024'(s_tready), 1024'(0));
    chk("bp_mvalid", 1024'(m_tvalid), 1024'(1));
    rdy_mode = 0;
    drain(200);

    // 1000 single-beat packets from requesters 1 and 3, random stall.
    exp_cnt  = model_pkts + 1000;
    rdy_mode = 2;
    for (int k = 0; k < 500; k++) begin
      add_pkt(1, 1);
      add_pkt(3, 1);
    end
    plan();
    drain(20000);
    chk("single_pktcnt", 1024'(pkt_cnt), 1024'(exp_cnt));

    // Reset mid-packet with the output buffer full.
    rdy_mode = 1;
    base = hs_cnt[2];
    add_pkt(2, 6);
    plan();
    n = 0;
    while (n < 20 && !((hs_cnt[2] - base) >= 2 && s_tready == '0)) begin
      cycle();
      n++;
    end
    chk("mid_buffered", 1024'(hs_cnt[2] - base), 1024'(2));
    chk("mid_full_mvalid", 1024'(m_tvalid), 1024'(1));
    user_reset_n = 1'b0;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_q[i].delete();
      plan_q[i].delete();
      plan_len[i].delete();
      stall_cnt[i] = 0;
    end
    exp_q.delete();
    rr_model   = 0;
    model_pkts = 0;
    prev_stall = 1'b0;
    chk("mid_rst_mvalid", 1024'(m_tvalid), 1024'(0));
    chk("mid_rst_gact", 1024'(grant_active), 1024'(0));
    chk("mid_rst_pktcnt", 1024'(pkt_cnt), 1024'(0));
    chk("mid_rst_sready", 1024'(s_tready), 1024'(0));
    rdy_mode = 0;
    cycle();
    chk("mid_rst_mvalid2", 1024'(m_tvalid), 1024'(0));
    cycle();
    user_reset_n = 1'b1;
    add_pkt(3, 2);
    add_pkt(0, 2);
    plan();
    n = 0;
    while (n < 20 && !grant_active) begin
      cycle();
      n++;
    end
    chk("restart_gid", 1024'({grant_active, grant_id}), 1024'({1'b1, 3'd0}));
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
